// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between core writeback (req0)
// and a debug writer (req1), with one registered output stage doubling as a forwarding tap.
module rf_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic          last_grant
);

  logic          r_out_valid;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd;
  logic          r_last_grant;

  logic          w_open;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_nonzero;

  // On contention the requester that did not win last time goes first.
  assign w_open   = !hold && !reset;
  assign w_grant0 = w_open && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_open && req1_valid && (!req0_valid || !r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_a3         <= '0;
      r_wd         <= '0;
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_out_valid  <= 1'b1;
      r_a3         <= req0_addr;
      r_wd         <= req0_data;
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_out_valid  <= 1'b1;
      r_a3         <= req1_addr;
      r_wd         <= req1_data;
      r_last_grant <= 1'b1;
    end else begin
      r_out_valid  <= 1'b0;
    end
  end

  // Reset squashes the write already sitting in the output stage, so the RF never sees it.
  assign w_nonzero  = (r_a3 != '0);
  assign rf_we      = r_out_valid && w_nonzero && !reset;
  assign rf_a3      = r_a3;
  assign rf_wd      = r_wd;
  assign fwd_valid  = rf_we;
  assign fwd_addr   = r_a3;
  assign fwd_data   = r_wd;
  assign last_grant = r_last_grant;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter: per-cycle comparison against a transaction-level
// model of the arbiter plus a shadow register file compared at the end.
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hold = 1'b0;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          last_grant;

  rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Pending requests per requester; the head is offered until it is accepted.
  req_t q0[$];
  req_t q1[$];

  // Model of what sits in the output stage and who won last.
  bit            m_init = 1'b0;
  bit            m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_last = 1'b1;

  logic [DW-1:0] exp_rf [32];
  logic [DW-1:0] obs_rf [32];
  int            a3_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit hld);
    bit   e0, e1, exp_we, seen0, seen1;
    req_t h0, h1;
    @(negedge clk);
    reset = rst;
    hold  = hld;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    req0_valid = (q0.size() > 0);
    req0_addr  = h0.a;
    req0_data  = h0.d;
    req1_valid = (q1.size() > 0);
    req1_addr  = h1.a;
    req1_data  = h1.d;
    #1;
    // Grant rule: blocked by hold/reset; lone requester wins; contention goes to the non-last winner.
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !hld) begin
      if (req0_valid && !req1_valid) e0 = 1'b1;
      else if (req1_valid && !req0_valid) e1 = 1'b1;
      else if (req0_valid && req1_valid) begin
        if (m_last == 1'b1) e0 = 1'b1; else e1 = 1'b1;
      end
    end
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    exp_we = m_valid && (m_addr != 0) && !rst;
    check_eq("rf_we", rf_we, exp_we);
    check_eq("fwd_valid", fwd_valid, exp_we);
    if (m_init) begin
      check_eq("rf_a3", rf_a3, m_addr);
      check_eq("rf_wd", rf_wd, m_data);
      check_eq("fwd_addr", fwd_addr, m_addr);
      check_eq("fwd_data", fwd_data, m_data);
      check_eq("last_grant", last_grant, m_last);
    end
    seen0 = req0_ready;
    seen1 = req1_ready;
    if (rf_we === 1'b1) begin
      obs_rf[rf_a3] = rf_wd;
      a3_log.push_back(int'(rf_a3));
    end
    if (exp_we) exp_rf[m_addr] = m_data;
    $display("cyc t=%0t rst=%0d hold=%0d v0=%0d v1=%0d rdy=%0d%0d we=%0d a3=%0d wd=%08h",
             $time, rst, hld, req0_valid, req1_valid, seen0, seen1, rf_we, rf_a3, rf_wd);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_addr = '0; m_data = '0; m_last = 1'b1; m_init = 1'b1;
    end else if (e0) begin
      m_valid = 1'b1; m_addr = h0.a; m_data = h0.d; m_last = 1'b0;
    end else if (e1) begin
      m_valid = 1'b1; m_addr = h1.a; m_data = h1.d; m_last = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (seen0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
    if (seen1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      run_cycle(1'b0, 1'b0);
      n++;
    end
    check_eq("drain_queues_empty", q0.size() + q1.size(), 0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int exp_seq[8];
    logic [DW-1:0] r9_before;
    exp_seq = '{1, 11, 2, 12, 3, 13, 4, 14};
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = '0;
      obs_rf[i] = '0;
    end

    // Reset with both requesters valid: nothing may be granted.
    q0.push_back('{a: 5'd3, d: 32'h1111_1111});
    q1.push_back('{a: 5'd4, d: 32'h2222_2222});
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    check_eq("reset_last_grant", last_grant, 1'b1);
    q0.delete();
    q1.delete();
    run_cycle(1'b0, 1'b0);

    // Single write to x5.
    q0.push_back('{a: 5'd5, d: 32'hDEAD_BEEF});
    drain(10);

    // Contention after a fresh reset: grants alternate starting with req0.
    run_cycle(1'b1, 1'b0);
    a3_log.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{a: AW'(1 + k), d: 32'hA000_0000 + k});
      q1.push_back('{a: AW'(11 + k), d: 32'hB000_0000 + k});
    end
    drain(20);
    check_eq("contention_len", a3_log.size(), 8);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("contention_a3_%0d", k), (k < a3_log.size()) ? a3_log[k] : -1, exp_seq[k]);

    // Write to x0 is accepted but never reaches the RF.
    q1.push_back('{a: 5'd0, d: 32'h0000_1234});
    drain(10);

    // hold blocks new grants while the accepted write still drains.
    q0.push_back('{a: 5'd7, d: 32'h7777_0007});
    run_cycle(1'b0, 1'b0);
    q1.push_back('{a: 5'd8, d: 32'h8888_0008});
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    drain(10);

    // Reset right after acceptance squashes the pending x9 write.
    r9_before = obs_rf[9];
    q0.push_back('{a: 5'd9, d: 32'h9999_0009});
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    check_eq("reset_squash_x9", obs_rf[9], r9_before);

    // Randomized traffic with occasional hold and reset.
    for (int c = 0; c < 600; c++) begin
      bit rst_c, hld_c;
      if (q0.size() < 3 && $urandom_range(0, 2) != 0)
        q0.push_back('{a: AW'($urandom_range(0, 31)), d: DW'($urandom)});
      if (q1.size() < 3 && $urandom_range(0, 2) != 0)
        q1.push_back('{a: AW'($urandom_range(0, 31)), d: DW'($urandom)});
      rst_c = ($urandom_range(0, 79) == 0);
      hld_c = ($urandom_range(0, 5) == 0);
      run_cycle(rst_c, hld_c);
    end
    drain(40);

    for (int i = 0; i < 32; i++)
      check_eq($sformatf("rf_x%0d", i), obs_rf[i], exp_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
